// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: state
// encoding, opcode constants, mux-select encodings and the immediate
// format helper.
// Optional feature macro: MC_JAL_EN (builds the JAL state and J-immediate).
package riscv_ctrl_pkg;

  // One encoding per FSM state; the JAL slot is reserved even when the
  // JAL state is not built so the debug encoding never shifts.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, never on the FSM state.
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    logic [1:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
`ifdef MC_JAL_EN
      OP_JAL:    imm = IMM_J;
`endif
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Control-word decoder: maps the current state, plus the memory ready and
// ALU zero qualifiers, onto the datapath strobes and mux selects.
// Optional feature macro: MC_JAL_EN (adds the JAL state's control word).
module mc_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal
);

  // Everything defaults low; each state only raises what it needs.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (state_t'(state))
      S_FETCH: begin
        mem_req    = 1'b1;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
`endif
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core. Holds the state register
// and next-state logic; the control word comes from mc_ctrl_decode.
// Optional feature macro: MC_JAL_EN (JAL support; otherwise jal is illegal).
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic       zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t state;

  // State register and transitions; memory states hold until MemReady,
  // ILLEGAL holds until reset, unused encodings fall into ILLEGAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (MemReady) state <= S_DECODE;
        end
        S_DECODE: begin
          case (Op)
            OP_LOAD,
            OP_STORE:  state <= S_MEMADR;
            OP_RTYPE:  state <= S_EXECR;
            OP_ITYPE:  state <= S_EXECI;
            OP_BRANCH: state <= S_BEQ;
`ifdef MC_JAL_EN
            OP_JAL:    state <= S_JAL;
`endif
            default:   state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR: begin
          state <= (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          if (MemReady) state <= S_MEMWB;
        end
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: begin
          if (MemReady) state <= S_FETCH;
        end
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
`ifdef MC_JAL_EN
        S_JAL:      state <= S_ALUWB;
`endif
        S_ILLEGAL:  state <= S_ILLEGAL;
        default:    state <= S_ILLEGAL;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state      (state),
    .mem_ready  (MemReady),
    .zero       (zero),
    .mem_req    (MemReq),
    .mem_write  (MemWrite),
    .adr_src    (AdrSrc),
    .ir_write   (IRWrite),
    .pc_write   (PCWrite),
    .reg_write  (RegWrite),
    .result_src (ResultSrc),
    .alu_src_a  (ALUSrcA),
    .alu_src_b  (ALUSrcB),
    .alu_op     (ALUOp),
    .illegal    (Illegal)
  );

  assign ImmSrc = imm_src_for(Op);
  assign State  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is
// expanded into its expected per-cycle state sequence (including stall
// cycles) and every cycle's control word is checked against rules taken
// from the state table. Honours MC_JAL_EN the same way as the design.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic       zero;
  logic       MemReady;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] State;

  int total = 0;
  int bad = 0;
  int memWriteCycles = 0;

  typedef struct {
    state_t st;
    logic   mr;
    logic   z;
  } step_t;

  step_t plan[$];

  logic [14:0] actualCtrl;

  multicycle_controller dut (
    .clk       (clk),
    .rst       (rst),
    .Op        (Op),
    .zero      (zero),
    .MemReady  (MemReady),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .Illegal   (Illegal),
    .State     (State)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  assign actualCtrl = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal};

  // Hard stop in case something goes badly wrong with the sequencing.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] expected);
    total++;
    if (got !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expected);
    end
  endtask

  // Control word each state should show, written field by field from the
  // state table rather than state by state.
  function automatic logic [14:0] expectedCtrl(input state_t st, input logic mr,
                                               input logic z);
    logic       req, wr, adr, irw, pcw, rgw, ill;
    logic [1:0] res, sa, sb, aop;
    req = (st == S_FETCH) || (st == S_MEMREAD) || (st == S_MEMWRITE);
    wr  = (st == S_MEMWRITE);
    adr = (st == S_MEMREAD) || (st == S_MEMWRITE);
    irw = (st == S_FETCH) && mr;
    pcw = ((st == S_FETCH) && mr) || ((st == S_BEQ) && z) || (st == S_JAL);
    rgw = (st == S_MEMWB) || (st == S_ALUWB);
    ill = (st == S_ILLEGAL);
    res = (st == S_FETCH) ? 2'b10 : (st == S_MEMWB) ? 2'b01 : 2'b00;
    sa  = ((st == S_DECODE) || (st == S_JAL)) ? 2'b01 :
          ((st == S_MEMADR) || (st == S_EXECR) || (st == S_EXECI) ||
           (st == S_BEQ)) ? 2'b10 : 2'b00;
    sb  = ((st == S_FETCH) || (st == S_JAL)) ? 2'b10 :
          ((st == S_DECODE) || (st == S_MEMADR) || (st == S_EXECI)) ? 2'b01 : 2'b00;
    aop = ((st == S_EXECR) || (st == S_EXECI)) ? 2'b10 :
          (st == S_BEQ) ? 2'b01 : 2'b00;
    return {req, wr, adr, irw, pcw, rgw, res, sa, sb, aop, ill};
  endfunction

  function automatic logic [1:0] expectedImm(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
`ifdef MC_JAL_EN
    if (op == 7'b1101111) return 2'b11;
`endif
    return 2'b00;
  endfunction

  function automatic bit isLegal(input logic [6:0] op);
    bit legal;
    legal = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
            (op == 7'b0010011) || (op == 7'b1100011);
`ifdef MC_JAL_EN
    legal = legal || (op == 7'b1101111);
`endif
    return legal;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // One clock: drive qualifiers, check mid-cycle, advance to just after the edge.
  task automatic stepCycle(input state_t st, input logic mr, input logic z,
                           input string tag);
    MemReady = mr;
    zero = z;
    @(negedge clk);
    checkOutput({tag, "_state"}, 32'(State), 32'(st));
    checkOutput({tag, "_ctrl"}, 32'(actualCtrl), 32'(expectedCtrl(st, mr, z)));
    checkOutput({tag, "_imm"}, 32'(ImmSrc), 32'(expectedImm(Op)));
    if (MemWrite) memWriteCycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    MemReady = rbit();
    zero = rbit();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Expected sequence of one instruction with the given stall counts.
  task automatic buildPlan(input logic [6:0] op, input int fStall,
                           input int mStall, input logic z);
    plan.delete();
    for (int i = 0; i < fStall; i++) plan.push_back('{S_FETCH, 1'b0, rbit()});
    plan.push_back('{S_FETCH, 1'b1, rbit()});
    plan.push_back('{S_DECODE, rbit(), rbit()});
    if (op == 7'b0000011) begin
      plan.push_back('{S_MEMADR, rbit(), rbit()});
      for (int i = 0; i < mStall; i++) plan.push_back('{S_MEMREAD, 1'b0, rbit()});
      plan.push_back('{S_MEMREAD, 1'b1, rbit()});
      plan.push_back('{S_MEMWB, rbit(), rbit()});
    end else if (op == 7'b0100011) begin
      plan.push_back('{S_MEMADR, rbit(), rbit()});
      for (int i = 0; i < mStall; i++) plan.push_back('{S_MEMWRITE, 1'b0, rbit()});
      plan.push_back('{S_MEMWRITE, 1'b1, rbit()});
    end else if (op == 7'b0110011) begin
      plan.push_back('{S_EXECR, rbit(), rbit()});
      plan.push_back('{S_ALUWB, rbit(), rbit()});
    end else if (op == 7'b0010011) begin
      plan.push_back('{S_EXECI, rbit(), rbit()});
      plan.push_back('{S_ALUWB, rbit(), rbit()});
    end else if (op == 7'b1100011) begin
      plan.push_back('{S_BEQ, rbit(), z});
    end else if (isLegal(op)) begin
      plan.push_back('{S_JAL, rbit(), rbit()});
      plan.push_back('{S_ALUWB, rbit(), rbit()});
    end else begin
      for (int i = 0; i < 10; i++) plan.push_back('{S_ILLEGAL, rbit(), rbit()});
    end
  endtask

  // Run one instruction; an illegal one is held ten cycles then reset away.
  task automatic applyStimulus(input logic [6:0] op, input int fStall,
                               input int mStall, input logic z, input string tag);
    Op = op;
    memWriteCycles = 0;
    buildPlan(op, fStall, mStall, z);
    foreach (plan[i]) stepCycle(plan[i].st, plan[i].mr, plan[i].z, tag);
    if (!isLegal(op)) begin
      doReset();
      stepCycle(S_FETCH, 1'b0, rbit(), {tag, "_after_rst"});
    end
  endtask

  initial begin
    rst = 1'b1;
    Op = 7'b0;
    zero = 1'b0;
    MemReady = 1'b0;
    doReset();

    $display("[TB] reset and first fetch");
    stepCycle(S_FETCH, 1'b0, 1'b0, "reset");
    checkOutput("reset_illegal", 32'(Illegal), 32'd0);

    $display("[TB] directed instructions");
    applyStimulus(7'b0000011, 0, 0, 1'b0, "lw");
    applyStimulus(7'b0100011, 0, 3, 1'b0, "sw_stall");
    checkOutput("sw_memwrite_cycles", 32'(memWriteCycles), 32'd4);
    applyStimulus(7'b1100011, 0, 0, 1'b1, "beq_taken");
    applyStimulus(7'b1100011, 0, 0, 1'b0, "beq_not");
    applyStimulus(7'b0110011, 2, 0, 1'b0, "rtype");
    applyStimulus(7'b0010011, 0, 0, 1'b0, "itype");
    applyStimulus(7'b1101111, 0, 0, 1'b0, "jal");
    applyStimulus(7'b1111111, 1, 0, 1'b0, "illegal");

    $display("[TB] reset during load stall");
    Op = 7'b0000011;
    stepCycle(S_FETCH, 1'b1, 1'b0, "rstmid");
    stepCycle(S_DECODE, 1'b0, 1'b0, "rstmid");
    stepCycle(S_MEMADR, 1'b1, 1'b0, "rstmid");
    stepCycle(S_MEMREAD, 1'b0, 1'b0, "rstmid");
    rst = 1'b1;
    stepCycle(S_MEMREAD, 1'b0, 1'b0, "rstmid_stall");
    rst = 1'b0;
    checkOutput("rstmid_regwrite", 32'(RegWrite), 32'd0);
    stepCycle(S_FETCH, 1'b0, 1'b0, "rstmid_fetch");

    $display("[TB] randomized instruction stream");
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 7))
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: op = 7'b1100011;
        5: op = 7'b1101111;
        6: op = 7'b0000011;
        default: op = 7'(($urandom_range(0, 127)));
      endcase
      applyStimulus(op, $urandom_range(0, 2), $urandom_range(0, 3), rbit(), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
